a_stim_driver: RTL and testbench
================================

// Module: a_stim_driver
// PURPOSE
//  Initiator-side driver for the (clk, d1, d2, b, c, d_ -> d3) port bundle.
//  Accepts one stimulus command via valid/ready, drives d1/d2/b/c/d_, waits
//  g_delay cycles for the consumer's response, then samples d3.
//  The sampled d3 is returned via a valid/ready response channel.
//  Sits between a test sequencer or host and the consumer module.
// PARAMETERS
//  g_w1     8   d1 width
//  g_w2     32  d2 width is g_w2+2
//  g_w3     16  d3 width is g_w3*2
//  g_delay  5   cycles from drive to d3 sample, legal 0..255 (8-bit counter)
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        reset, asynchronous, active-low
//  cmd_valid    in   1        command offered
//  cmd_ready    out  1        command accepted when valid&ready
//  cmd_d1       in   g_w1     value for d1
//  cmd_d2       in   g_w2+2   value for d2
//  cmd_b        in   4        value for b
//  cmd_c        in   4        value for c
//  cmd_d        in   4        value for d_
//  d1           out  g_w1     driven to consumer
//  d2           out  g_w2+2   driven to consumer
//  b            out  4        driven to consumer
//  c            out  4        driven to consumer
//  d_           out  4        driven to consumer
//  d3           in   g_w3*2   consumer response
//  rsp_valid    out  1        response available
//  rsp_ready    in   1        response taken when valid&ready
//  rsp_data     out  g_w3*2   sampled d3
//  busy         out  1        state != IDLE
// BEHAVIOUR
//  - Reset (rst_n low, async): state IDLE; cmd_ready, rsp_valid, busy,
//    rsp_data, d1, d2, b, c, d_ all 0; cnt 0. cmd_ready rises at the first
//    edge after rst_n releases.
//  - FSM IDLE -> DRIVE -> RESP -> IDLE; all outputs registered.
//  - IDLE: cmd_ready=1. On accept at edge E0, register cmd_* into d1..d_,
//    load cnt=g_delay, set cmd_ready=0, busy=1, and enter DRIVE.
//  - DRIVE: if cnt==0, capture d3 into rsp_data, set rsp_valid=1, and enter
//    RESP; else decrement cnt. d3 is captured at edge E0+g_delay+1.
//    cmd_valid to rsp_valid latency is g_delay+1 cycles.
//  - RESP: rsp_valid and rsp_data are held stable until rsp_ready. On the
//    handshake edge: rsp_valid=0, cmd_ready=1, busy=0, state IDLE.
//    rsp_ready high on the same edge rsp_valid rises has no effect.
//  - d1..d_ hold their last driven value after the response (no return to 0).
//  - Commands are never accepted outside IDLE. Minimum command spacing is
//    g_delay+3 cycles.
//  - cmd_valid dropping without a handshake is legal, and nothing is captured.
//  - Reset mid-operation aborts the transaction with no response, and all
//    outputs return to reset values.
//  - g_delay=0: d3 is sampled on the edge after the drive edge.
// CONFIGURATION
//  RESP_CHECK_EN defined adds these ports:
//    cmd_exp       in   g_w3*2
//    rsp_mismatch  out  1
//    err_cnt       out  8
//  - cmd_exp is latched on command accept.
//  - rsp_mismatch is set with rsp_valid when d3 != latched expected value,
//    and is held with rsp_data.
//  - err_cnt increments on each mismatching capture, saturates at 255, and
//    is cleared only by reset.
//  RESP_CHECK_EN undefined: these ports and the checking logic are absent.
// TESTING
//  1. Reset, then cmd d1=8'hA5 d2=34'h3_0000_0001 b=3 c=C d=F ->
//     outputs show these values one edge later; cmd_ready=0;
//     rsp_valid after exactly 6 edges (g_delay=5).
//  2. d3 changes from 32'h1111_1111 to 32'hDEAD_BEEF one cycle before the
//     sample edge -> rsp_data=32'hDEAD_BEEF.
//  3. rsp_ready held low 10 cycles -> rsp_data stable, cmd_ready=0, and a
//     cmd_valid pulse is ignored; rsp_ready=1 -> cmd_ready=1 next cycle.
//  4. rst_n low 2 cycles in DRIVE -> outputs 0, no rsp_valid;
//     a new cmd after release completes normally.
//  5. g_delay=0 build, back-to-back cmds with rsp_ready=1 -> cmds accepted
//     every 3 cycles, each rsp_data matches d3 at its sample edge.
//  6. RESP_CHECK_EN with cmd_exp=32'h1 and d3=32'h2 -> rsp_mismatch=1 and
//     err_cnt=1; 300 mismatches -> err_cnt=255.

Source files
------------

// File: rtl/a_stim_driver.sv
// a_stim_driver: initiator-side driver for the (d1, d2, b, c, d_ -> d3) bundle.
//   Takes one command per cmd_valid/cmd_ready handshake and drives d1/d2/b/c/d_.
//   Waits g_delay cycles, then samples d3.
//   Returns the sampled d3 on the rsp_valid/rsp_ready channel.
//   Ports: clk, rst_n (async, active-low), cmd_* (command in), d1/d2/b/c/d_ (drive out),
//          d3 (response in), rsp_* (response out), busy.
//   Optional macro RESP_CHECK_EN adds cmd_exp / rsp_mismatch / err_cnt response checking.
module a_stim_driver #(
    parameter int g_w1    = 8,
    parameter int g_w2    = 32,
    parameter int g_w3    = 16,
    parameter int g_delay = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [g_w1-1:0]     cmd_d1,
    input  logic [g_w2+1:0]     cmd_d2,
    input  logic [3:0]          cmd_b,
    input  logic [3:0]          cmd_c,
    input  logic [3:0]          cmd_d,
    output logic [g_w1-1:0]     d1,
    output logic [g_w2+1:0]     d2,
    output logic [3:0]          b,
    output logic [3:0]          c,
    output logic [3:0]          d_,
    input  logic [g_w3*2-1:0]   d3,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [g_w3*2-1:0]   rsp_data,
`ifdef RESP_CHECK_EN
    input  logic [g_w3*2-1:0]   cmd_exp,
    output logic                rsp_mismatch,
    output logic [7:0]          err_cnt,
`endif
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                busy_q, busy_d;
    logic [g_w3*2-1:0]   rsp_data_q, rsp_data_d;
    logic [g_w1-1:0]     d1_q, d1_d;
    logic [g_w2+1:0]     d2_q, d2_d;
    logic [3:0]          b_q, b_d, c_q, c_d, dd_q, dd_d;
`ifdef RESP_CHECK_EN
    logic [g_w3*2-1:0]   exp_q, exp_d;
    logic                mm_q, mm_d;
    logic [7:0]          err_q, err_d;
`endif
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        rsp_data_d  = rsp_data_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        b_d         = b_q;
        c_d         = c_q;
        dd_d        = dd_q;
`ifdef RESP_CHECK_EN
        exp_d       = exp_q;
        mm_d        = mm_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                // cmd_ready comes up one edge after reset release, never combinationally
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    d1_d        = cmd_d1;
                    d2_d        = cmd_d2;
                    b_d         = cmd_b;
                    c_d         = cmd_c;
                    dd_d        = cmd_d;
                    cnt_d       = 8'(g_delay);
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = DRIVE;
`ifdef RESP_CHECK_EN
                    exp_d       = cmd_exp;
`endif
                end
            end
            DRIVE: begin
                if (cnt_q == 8'd0) begin
                    rsp_data_d  = d3;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`ifdef RESP_CHECK_EN
                    mm_d        = d3 != exp_q;
                    err_d       = (d3 != exp_q && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                // registered rsp_valid_q makes rsp_ready on the rising edge a no-op
                if (rsp_ready && rsp_valid_q) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_data_q  <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            b_q         <= '0;
            c_q         <= '0;
            dd_q        <= '0;
`ifdef RESP_CHECK_EN
            exp_q       <= '0;
            mm_q        <= 1'b0;
            err_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            rsp_data_q  <= rsp_data_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            b_q         <= b_d;
            c_q         <= c_d;
            dd_q        <= dd_d;
`ifdef RESP_CHECK_EN
            exp_q       <= exp_d;
            mm_q        <= mm_d;
            err_q       <= err_d;
`endif
        end
    end
    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;
    assign rsp_data  = rsp_data_q;
    assign d1        = d1_q;
    assign d2        = d2_q;
    assign b         = b_q;
    assign c         = c_q;
    assign d_        = dd_q;
`ifdef RESP_CHECK_EN
    assign rsp_mismatch = mm_q;
    assign err_cnt      = err_q;
`endif
endmodule

// File: tb/tb_a_stim_driver.sv
// tb_a_stim_driver: randomized self-checking bench for a_stim_driver (g_delay=5 and g_delay=0 instances).
module tb_a_stim_driver;
    localparam int GD = 5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [7:0]  cmd_d1, d1;
    logic [33:0] cmd_d2, d2;
    logic [3:0]  cmd_b, cmd_c, cmd_d, b, c, d_;
    logic [31:0] d3, rsp_data;
    logic        b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready, b_busy;
    logic [7:0]  b_cmd_d1, b_d1;
    logic [33:0] b_d2;
    logic [3:0]  b_b, b_c, b_dd;
    logic [31:0] b_d3, b_rsp_data;
`ifdef RESP_CHECK_EN
    logic [31:0] cmd_exp;
    logic        rsp_mismatch, b_mm;
    logic [7:0]  err_cnt, b_err;
    int          exp_err = 0;
`endif

    a_stim_driver #(.g_delay(GD)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_d1(cmd_d1), .cmd_d2(cmd_d2), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d),
        .d1(d1), .d2(d2), .b(b), .c(c), .d_(d_), .d3(d3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef RESP_CHECK_EN
        .cmd_exp(cmd_exp), .rsp_mismatch(rsp_mismatch), .err_cnt(err_cnt),
`endif
        .busy(busy)
    );

    a_stim_driver #(.g_delay(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_d1(b_cmd_d1), .cmd_d2(34'h0), .cmd_b(4'h0), .cmd_c(4'h0), .cmd_d(4'h0),
        .d1(b_d1), .d2(b_d2), .b(b_b), .c(b_c), .d_(b_dd), .d3(b_d3),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
`ifdef RESP_CHECK_EN
        .cmd_exp(32'h0), .rsp_mismatch(b_mm), .err_cnt(b_err),
`endif
        .busy(b_busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        cmd_valid = 0; rsp_ready = 0; cmd_d1 = 0; cmd_d2 = 0; cmd_b = 0; cmd_c = 0; cmd_d = 0; d3 = 0;
        b_cmd_valid = 0; b_rsp_ready = 0; b_cmd_d1 = 0; b_d3 = 0;
`ifdef RESP_CHECK_EN
        cmd_exp = 0;
`endif
        rst_n = 0;
        repeat (2) step;
        total++;
        if ({cmd_ready, rsp_valid, busy, rsp_data, d1, d2, b, c, d_} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {cmd_ready, rsp_valid, busy, rsp_data, d1, d2, b, c, d_});
        end
        rst_n = 1;
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b exp=0", cmd_ready); end
        step;
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || b_cmd_ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_release got=%b%b%b exp=101", cmd_ready, busy, b_cmd_ready);
        end
`ifdef RESP_CHECK_EN
        exp_err = 0;
        total++;
        if (err_cnt !== 8'h0 || rsp_mismatch !== 1'b0) begin bad++; $display("FAIL reset_err got=%h exp=0", err_cnt); end
`endif
    endtask

    // mode 0: random data; mode 1: fixed directed values with d3 switching just before sampling;
    // mode 2: d3=2 against expected 1 (forced mismatch)
    task automatic run_txn(input int mode, input int hold, input bit early, input bit pulse);
        logic [7:0]  v1;
        logic [33:0] v2;
        logic [3:0]  vb, vc, vd;
        logic [31:0] sv;
        int k;
`ifdef RESP_CHECK_EN
        logic [31:0] ev;
        logic mm;
`endif
        v1 = mode == 1 ? 8'hA5 : 8'($urandom);
        v2 = mode == 1 ? 34'h3_0000_0001 : 34'({$urandom, $urandom});
        vb = mode == 1 ? 4'h3 : 4'($urandom);
        vc = mode == 1 ? 4'hC : 4'($urandom);
        vd = mode == 1 ? 4'hF : 4'($urandom);
        sv = mode == 1 ? 32'hDEAD_BEEF : mode == 2 ? 32'h2 : $urandom;
`ifdef RESP_CHECK_EN
        ev = mode == 2 ? 32'h1 : ($urandom_range(0, 1) == 1 ? sv : $urandom);
        cmd_exp = ev;
`endif
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", cmd_ready); end
        cmd_valid = 1; cmd_d1 = v1; cmd_d2 = v2; cmd_b = vb; cmd_c = vc; cmd_d = vd;
        d3 = mode == 1 ? 32'h1111_1111 : $urandom;
        rsp_ready = early;
        step;
        cmd_valid = 0; cmd_d1 = ~v1; cmd_d2 = ~v2; cmd_b = ~vb; cmd_c = ~vc; cmd_d = ~vd;
        total++;
        if ({d1, d2, b, c, d_, cmd_ready, busy} !== {v1, v2, vb, vc, vd, 1'b0, 1'b1}) begin
            bad++; $display("FAIL drive got=%h exp=%h", {d1, d2, b, c, d_, cmd_ready, busy}, {v1, v2, vb, vc, vd, 1'b0, 1'b1});
        end
        for (k = 1; k <= 40; k++) begin
            d3 = (k == GD + 1) ? sv : (mode == 1 ? 32'h1111_1111 : $urandom);
            step;
            if (rsp_valid === 1'b1) break;
        end
        total++;
        if (k != GD + 1) begin bad++; $display("FAIL latency got=%0d exp=%0d", k, GD + 1); end
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== sv) begin
            bad++; $display("FAIL rsp_data got=%b/%h exp=1/%h", rsp_valid, rsp_data, sv);
        end
`ifdef RESP_CHECK_EN
        mm = sv != ev;
        if (mm && exp_err < 255) exp_err++;
        total++;
        if (rsp_mismatch !== mm || err_cnt !== 8'(exp_err)) begin
            bad++; $display("FAIL check got=%b/%0d exp=%b/%0d", rsp_mismatch, err_cnt, mm, exp_err);
        end
`endif
        for (int i = 0; i < hold; i++) begin
            d3 = $urandom;
            cmd_valid = pulse && i == 2;
            step;
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== sv || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL hold got=%b/%h/%b exp=1/%h/0", rsp_valid, rsp_data, cmd_ready, sv);
            end
        end
        cmd_valid = 0;
        rsp_ready = 1;
        step;
        rsp_ready = 0;
        total++;
        if ({rsp_valid, cmd_ready, busy, d1, d2, b, c, d_} !== {1'b0, 1'b1, 1'b0, v1, v2, vb, vc, vd}) begin
            bad++; $display("FAIL release got=%h exp=%h", {rsp_valid, cmd_ready, busy, d1, d2, b, c, d_}, {1'b0, 1'b1, 1'b0, v1, v2, vb, vc, vd});
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 20; n++) begin
            bit e;
            e = $urandom_range(0, 1) == 1;
            run_txn(0, e ? 0 : $urandom_range(0, 4), e, $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic test_reset_mid;
        cmd_valid = 1; cmd_d1 = 8'h5A; cmd_d2 = 34'h1_2345_6789; cmd_b = 4'h1; cmd_c = 4'h2; cmd_d = 4'h3;
        step;
        cmd_valid = 0;
        repeat (2) step;
        rst_n = 0;
        #1;
        total++;
        if ({cmd_ready, rsp_valid, busy, rsp_data, d1, d2, b, c, d_} !== '0) begin
            bad++; $display("FAIL mid_reset got=%h exp=0", {cmd_ready, rsp_valid, busy, rsp_data, d1, d2, b, c, d_});
        end
        repeat (2) step;
        rst_n = 1;
`ifdef RESP_CHECK_EN
        exp_err = 0;
`endif
        for (int i = 0; i < 10; i++) begin
            step;
            total++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                bad++; $display("FAIL after_reset got=%b%b exp=01", rsp_valid, cmd_ready);
            end
        end
        run_txn(0, 1, 0, 0);
    endtask

    task automatic test_back_to_back;
        logic [7:0]  a1[30];
        logic [31:0] a3[30];
        total++;
        if (b_cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b exp=1", b_cmd_ready); end
        b_cmd_valid = 1;
        b_rsp_ready = 1;
        for (int i = 0; i < 30; i++) begin
            a1[i] = 8'($urandom);
            a3[i] = $urandom;
            b_cmd_d1 = a1[i];
            b_d3 = a3[i];
            step;
            total++;
            if (i % 3 == 0 && (b_d1 !== a1[i] || b_cmd_ready !== 1'b0 || b_rsp_valid !== 1'b0)) begin
                bad++; $display("FAIL b2b_accept i=%0d got=%h/%b/%b exp=%h/0/0", i, b_d1, b_cmd_ready, b_rsp_valid, a1[i]);
            end
            if (i % 3 == 1 && (b_rsp_valid !== 1'b1 || b_rsp_data !== a3[i])) begin
                bad++; $display("FAIL b2b_rsp i=%0d got=%b/%h exp=1/%h", i, b_rsp_valid, b_rsp_data, a3[i]);
            end
            if (i % 3 == 2 && (b_rsp_valid !== 1'b0 || b_cmd_ready !== 1'b1 || b_busy !== 1'b0)) begin
                bad++; $display("FAIL b2b_done i=%0d got=%b%b%b exp=010", i, b_rsp_valid, b_cmd_ready, b_busy);
            end
        end
        b_cmd_valid = 0;
        b_rsp_ready = 0;
    endtask

`ifdef RESP_CHECK_EN
    task automatic test_err_sat;
        for (int n = 0; n < 300; n++) run_txn(2, 0, 0, 0);
        total++;
        if (err_cnt !== 8'hFF) begin bad++; $display("FAIL err_sat got=%0d exp=255", err_cnt); end
    endtask
`endif

    initial begin
        test_reset;
        run_txn(1, 0, 0, 0);
        run_txn(0, 10, 0, 1);
        run_txn(0, 0, 1, 0);
        test_random;
        test_reset_mid;
        test_back_to_back;
`ifdef RESP_CHECK_EN
        test_err_sat;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
